// File: rtl/video_timing_core.sv
// rtl/video_timing_core.sv - programmable raster timing generator with shadowed config
module video_timing_core #(
    parameter int CNT_W    = 12,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] cfg_h_act,
    input  logic [CNT_W-1:0] cfg_h_fp,
    input  logic [CNT_W-1:0] cfg_h_sync,
    input  logic [CNT_W-1:0] cfg_h_bp,
    input  logic [CNT_W-1:0] cfg_v_act,
    input  logic [CNT_W-1:0] cfg_v_fp,
    input  logic [CNT_W-1:0] cfg_v_sync,
    input  logic [CNT_W-1:0] cfg_v_bp,
    input  logic             cfg_load,
    output logic             cfg_pending,
    output logic             hs,
    output logic             vs,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             sol,
    output logic             eol,
    output logic             sof,
    output logic             eof
);
    localparam int TW = CNT_W + 2;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef struct packed {
        logic [CNT_W-1:0] h_act;
        logic [CNT_W-1:0] h_fp;
        logic [CNT_W-1:0] h_sync;
        logic [CNT_W-1:0] h_bp;
        logic [CNT_W-1:0] v_act;
        logic [CNT_W-1:0] v_fp;
        logic [CNT_W-1:0] v_sync;
        logic [CNT_W-1:0] v_bp;
    } timing_t;

    localparam timing_t DEF_CFG = timing_t'({
        CNT_W'(H_ACTIVE), CNT_W'(H_FRONT), CNT_W'(H_SYNC), CNT_W'(H_BACK),
        CNT_W'(V_ACTIVE), CNT_W'(V_FRONT), CNT_W'(V_SYNC), CNT_W'(V_BACK)});

    timing_t          r_cfg, r_shadow;
    logic             r_pending;
    logic [CNT_W-1:0] r_h, r_v, r_x, r_y;
    logic             r_hs, r_vs, r_de, r_sol, r_eol, r_sof, r_eof;

    timing_t          w_cfg_in;
    logic [TW-1:0]    w_h, w_v;
    logic [TW-1:0]    w_h_ss, w_h_se, w_h_tot, w_v_ss, w_v_se, w_v_tot;
    logic             w_h_last, w_v_last, w_apply;
    logic             w_h_vis, w_v_vis, w_de, w_hs_on, w_vs_on;
    logic             w_h_first, w_h_end;

    assign w_cfg_in = timing_t'({cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp,
                                 cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp});

    // Sums kept two bits wider so a maximal legal total cannot wrap.
    assign w_h      = TW'(r_h);
    assign w_v      = TW'(r_v);
    assign w_h_ss   = TW'(r_cfg.h_act) + TW'(r_cfg.h_fp);
    assign w_h_se   = w_h_ss + TW'(r_cfg.h_sync);
    assign w_h_tot  = w_h_se + TW'(r_cfg.h_bp);
    assign w_v_ss   = TW'(r_cfg.v_act) + TW'(r_cfg.v_fp);
    assign w_v_se   = w_v_ss + TW'(r_cfg.v_sync);
    assign w_v_tot  = w_v_se + TW'(r_cfg.v_bp);

    assign w_h_last  = (w_h == w_h_tot - TW'(1));
    assign w_v_last  = (w_v == w_v_tot - TW'(1));
    assign w_apply   = en && w_h_last && w_v_last && r_pending;

    assign w_h_vis   = (r_h < r_cfg.h_act);
    assign w_v_vis   = (r_v < r_cfg.v_act);
    assign w_de      = w_h_vis && w_v_vis;
    assign w_hs_on   = (w_h >= w_h_ss) && (w_h < w_h_se);
    assign w_vs_on   = (w_v >= w_v_ss) && (w_v < w_v_se);
    assign w_h_first = (r_h == '0);
    assign w_h_end   = (r_h == r_cfg.h_act - ONE);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_h       <= '0;
            r_v       <= '0;
            r_cfg     <= DEF_CFG;
            r_shadow  <= DEF_CFG;
            r_pending <= 1'b0;
            r_hs      <= ~HS_POL;
            r_vs      <= ~VS_POL;
            r_de      <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_sol     <= 1'b0;
            r_eol     <= 1'b0;
            r_sof     <= 1'b0;
            r_eof     <= 1'b0;
        end else begin
            if (en) begin
                r_de  <= w_de;
                r_x   <= w_de ? r_h : '0;
                r_y   <= w_de ? r_v : '0;
                r_hs  <= w_hs_on ? HS_POL : ~HS_POL;
                r_vs  <= w_vs_on ? VS_POL : ~VS_POL;
                r_sol <= w_h_first && w_v_vis;
                r_eol <= w_h_end && w_v_vis;
                r_sof <= w_h_first && (r_v == '0);
                r_eof <= w_h_end && (r_v == r_cfg.v_act - ONE);
                if (w_h_last) begin
                    r_h <= '0;
                    r_v <= w_v_last ? '0 : r_v + ONE;
                end else begin
                    r_h <= r_h + ONE;
                end
                if (w_apply) r_cfg <= r_shadow;
            end
            // A load coinciding with apply keeps the new values pending for the next frame.
            if (cfg_load) begin
                r_shadow  <= w_cfg_in;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign cfg_pending = r_pending;
    assign hs  = r_hs;
    assign vs  = r_vs;
    assign de  = r_de;
    assign x   = r_x;
    assign y   = r_y;
    assign sol = r_sol;
    assign eol = r_eol;
    assign sof = r_sof;
    assign eof = r_eof;
endmodule
